// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- run controller for the pipelined cpu core.
//
// Holds the core in reset for RST_CYCLES cycles after a start pulse, then lets
// it run while counting cycles. A run ends on halt (PC unchanged for
// STALL_LIMIT consecutive samples) or on timeout (MAX_CYCLES run cycles).
// When both happen on the same edge, halt is reported.
//
// Optional feature macro: CPU_RUN_PERF_EN -- adds change_count, the number of
// run edges on which the PC advanced. It saturates at all-ones.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   start        pulse that begins a run from IDLE or DONE
//   pc_in        observed core PC
//   cpu_rst      reset to the core (high in IDLE and RESET)
//   running      high in RUN
//   done         high in DONE
//   halted       run ended by halt detection (valid while done)
//   timeout      run ended by MAX_CYCLES (valid while done)
//   cycle_count  RUN cycles elapsed in the current or last run
//   change_count PC-advance count (CPU_RUN_PERF_EN only)
module cpu_run_ctrl #(
  parameter int PC_WIDTH    = 32,
  parameter int CNT_WIDTH   = 16,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1000,
  parameter int STALL_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pc_in,
  output logic                 cpu_rst,
  output logic                 running,
  output logic                 done,
  output logic                 halted,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
`ifdef CPU_RUN_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] change_count
`endif
);

  // rst_cnt counts 0..RST_CYCLES-1. same_cnt counts 0..STALL_LIMIT-1.
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SW = $clog2(STALL_LIMIT);

  // Parameter legality. A bad parameter value stops elaboration.
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("cpu_run_ctrl: RST_CYCLES must be >= 1");
  end
  if (STALL_LIMIT < 2) begin : g_bad_stall
    $error("cpu_run_ctrl: STALL_LIMIT must be >= 2");
  end
  if (MAX_CYCLES < 1 || longint'(MAX_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_max
    $error("cpu_run_ctrl: MAX_CYCLES must be in [1, 2**CNT_WIDTH)");
  end

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [RW-1:0]         rst_cnt;
  logic [PC_WIDTH-1:0]   last_pc;
  logic [SW-1:0]         same_cnt;
  logic                  first_run;  // the next RUN edge only loads last_pc
  logic                  pc_same, halt_hit, tmo_hit;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  always_comb begin
    state_nxt = state;
    pc_same   = (pc_in == last_pc);
    cnt_inc   = cycle_count + CNT_WIDTH'(1);
    halt_hit  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RESET;
      S_RESET: if (rst_cnt == RW'(RST_CYCLES - 1)) state_nxt = S_RUN;
      S_RUN: begin
        if (!first_run) begin
          // same_cnt holds the number of earlier equal samples, minus one.
          // This sample is equal too, so STALL_LIMIT equal samples are reached
          // when same_cnt is STALL_LIMIT-2.
          halt_hit = pc_same && (same_cnt == SW'(STALL_LIMIT - 2));
          tmo_hit  = (cnt_inc == CNT_WIDTH'(MAX_CYCLES));
          if (halt_hit || tmo_hit) state_nxt = S_DONE;
        end
      end
      S_DONE:  if (start) state_nxt = S_RESET;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rst     <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      same_cnt    <= '0;
      last_pc     <= '0;
      rst_cnt     <= '0;
      first_run   <= 1'b1;
`ifdef CPU_RUN_PERF_EN
      change_count <= '0;
`endif
    end else begin
      // Status outputs are registered decodes of the next state.
      cpu_rst <= (state_nxt == S_IDLE) || (state_nxt == S_RESET);
      running <= (state_nxt == S_RUN);
      done    <= (state_nxt == S_DONE);

      if (state_nxt == S_RESET && state != S_RESET) begin
        // A new run starts here. Counters are cleared on the start edge.
        rst_cnt     <= '0;
        cycle_count <= '0;
        halted      <= 1'b0;
        timeout     <= 1'b0;
        first_run   <= 1'b1;
`ifdef CPU_RUN_PERF_EN
        change_count <= '0;
`endif
      end else if (state == S_RESET) begin
        rst_cnt <= rst_cnt + 1'b1;
      end

      if (state == S_RUN) begin
        first_run <= 1'b0;
        if (first_run) begin
          last_pc  <= pc_in;
          same_cnt <= '0;
        end else begin
          cycle_count <= cnt_inc;
          if (pc_same) begin
            same_cnt <= same_cnt + 1'b1;
          end else begin
            same_cnt <= '0;
            last_pc  <= pc_in;
`ifdef CPU_RUN_PERF_EN
            if (change_count != '1) change_count <= change_count + 1'b1;
`endif
          end
          halted  <= halt_hit;
          timeout <= tmo_hit && !halt_hit;  // halt has priority over timeout
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl. Two instances share the stimulus:
//   u0: MAX_CYCLES=1000, STALL_LIMIT=8
//   u1: MAX_CYCLES=10,   STALL_LIMIT=2
// A reference model works out each run's outcome from the PC sample list.
// The expected outcome goes into a queue when the run starts. A monitor pops
// the queue and compares when done rises.
module tb_cpu_run_ctrl;
  localparam int PCW = 32, CW0 = 16, CW1 = 8, RSTC = 2;
  localparam int MAX0 = 1000, STALL0 = 8, MAX1 = 10, STALL1 = 2;

  logic clk = 1'b0;
  logic rst, start;
  logic [PCW-1:0] pc_in;
  logic cpu_rst0, run0, done0, halt0, tmo0;
  logic cpu_rst1, run1, done1, halt1, tmo1;
  logic [CW0-1:0] cc0;
  logic [CW1-1:0] cc1;
`ifdef CPU_RUN_PERF_EN
  logic [CW0-1:0] chg0;
  logic [CW1-1:0] chg1;
`endif

  always #5 clk = ~clk;

  cpu_run_ctrl #(.PC_WIDTH(PCW), .CNT_WIDTH(CW0), .RST_CYCLES(RSTC),
                 .MAX_CYCLES(MAX0), .STALL_LIMIT(STALL0)) u0 (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .cpu_rst(cpu_rst0), .running(run0), .done(done0), .halted(halt0),
    .timeout(tmo0), .cycle_count(cc0)
`ifdef CPU_RUN_PERF_EN
    , .change_count(chg0)
`endif
  );

  cpu_run_ctrl #(.PC_WIDTH(PCW), .CNT_WIDTH(CW1), .RST_CYCLES(RSTC),
                 .MAX_CYCLES(MAX1), .STALL_LIMIT(STALL1)) u1 (
    .clk(clk), .rst(rst), .start(start), .pc_in(pc_in),
    .cpu_rst(cpu_rst1), .running(run1), .done(done1), .halted(halt1),
    .timeout(tmo1), .cycle_count(cc1)
`ifdef CPU_RUN_PERF_EN
    , .change_count(chg1)
`endif
  );

  typedef struct {
    bit halted;
    bit timeout;
    int cc;
    int chg;
  } exp_t;

  exp_t q0[$], q1[$];
  logic [PCW-1:0] seq[$];  // PC presented on RUN edge k is seq[k]
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model. RUN edge 0 only loads the PC. On edge k>=1, cycle_count
  // becomes k. The run stops at the first k where the last `stall` samples are
  // all equal (halt), or at k == maxc (timeout). Halt wins a tie.
  function automatic exp_t model(input int stall, input int maxc, input int cw);
    exp_t r;
    int run;
    r = '{0, 0, 0, 0};
    run = 1;
    for (int k = 1; k < seq.size(); k++) begin
      if (seq[k] == seq[k-1]) run++;
      else begin
        run = 1;
        if (r.chg < (1 << cw) - 1) r.chg++;
      end
      r.cc = k;
      if (run >= stall) begin r.halted = 1; return r; end
      if (k == maxc) begin r.timeout = 1; return r; end
    end
    return r;
  endfunction

  task automatic build(input int kind);
    logic [PCW-1:0] p;
    int hold;
    seq.delete();
    case (kind)
      0: for (int k = 0; k <= MAX0; k++) seq.push_back(k <= 8 ? PCW'(k * 4) : 32'h20);
      1: begin
        p = $urandom & ~32'h3;
        for (int k = 0; k <= MAX0; k++) seq.push_back(p + PCW'(k * 4));
      end
      2: for (int k = 0; k <= MAX0; k++) seq.push_back(PCW'((k / 7) * 4));  // 7-sample holds
      3: for (int k = 0; k <= MAX0; k++) seq.push_back(PCW'((k <= 9 ? k : k - 1) * 4));
      default: begin
        p = $urandom & ~32'h3;
        while (seq.size() <= MAX0) begin
          hold = $urandom_range(1, 9);
          repeat (hold) if (seq.size() <= MAX0) seq.push_back(p);
          p = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'h3) : p + 4;
        end
      end
    endcase
  endtask

  // Pulse start. If `hold2` is set, start stays high over the first RESET
  // edge, where it must be ignored. Then check the counter clear and the
  // start-to-running latency.
  task automatic launch(input bit hold2);
    int n;
    start = 1'b1;
    @(negedge clk);
    chk("clear cc0", cc0, 0);
    chk("clear cc1", cc1, 0);
    chk("clear halted0", halt0, 0);
    chk("clear timeout0", tmo0, 0);
    chk("clear done0", done0, 0);
    chk("reset cpu_rst0", cpu_rst0, 1);
    start = hold2;
    n = 0;
    while (!run0 && n < 20) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (!run0) chk("cpu_rst0 held", cpu_rst0, 1);
    end
    chk("start latency", n, RSTC);
    chk("cpu_rst0 falls", cpu_rst0, 0);
    chk("running1 rises", run1, 1);
  endtask

  task automatic run_one(input int kind, input bit noisy);
    exp_t e0, e1;
    int idx, guard;
    build(kind);
    e0 = model(STALL0, MAX0, CW0);
    e1 = model(STALL1, MAX1, CW1);
    q0.push_back(e0);
    q1.push_back(e1);
    launch(noisy);
    idx = 0;
    guard = 0;
    while ((run0 || run1) && guard < MAX0 + 50) begin
      pc_in = seq[idx < seq.size() ? idx : seq.size() - 1];
      // A start pulse while both instances are running must be ignored.
      start = noisy && idx == 3 && run0 && run1;
      idx++;
      guard++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("run ends within bound", run0 || run1, 0);
    chk("frozen cc0", cc0, e0.cc);
    chk("frozen cc1", cc1, e1.cc);
    @(negedge clk);
  endtask

  task automatic reset_mid_run();
    int idx, guard;
    build(1);
    q1.push_back(model(STALL1, MAX1, CW1));  // u1 times out before the reset
    launch(1'b0);
    idx = 0;
    guard = 0;
    while (cc0 != 37 && guard < 200) begin
      pc_in = seq[idx];
      idx++;
      guard++;
      @(negedge clk);
    end
    chk("reach cycle 37", cc0, 37);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst cpu_rst", cpu_rst0, 1);
    chk("midrst running", run0, 0);
    chk("midrst done", done0, 0);
    chk("midrst cc", cc0, 0);
    chk("midrst halted", halt0, 0);
    chk("midrst timeout", tmo0, 0);
    repeat (3) @(negedge clk);
    chk("idle waits for start", {cpu_rst0, run0, done0}, 3'b100);
  endtask

  // Monitor: compare on each rising edge of done.
  initial begin
    logic pd0, pd1;
    exp_t e;
    pd0 = 1'b0;
    pd1 = 1'b0;
    forever begin
      @(negedge clk);
      if (done0 && !pd0) begin
        if (q0.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL u0 unexpected done: got 1 expected 0");
        end else begin
          e = q0.pop_front();
          chk("u0 halted", halt0, e.halted);
          chk("u0 timeout", tmo0, e.timeout);
          chk("u0 cycle_count", cc0, e.cc);
          chk("u0 running low", run0, 0);
          chk("u0 cpu_rst low", cpu_rst0, 0);
`ifdef CPU_RUN_PERF_EN
          chk("u0 change_count", chg0, e.chg);
`endif
        end
      end
      if (done1 && !pd1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL u1 unexpected done: got 1 expected 0");
        end else begin
          e = q1.pop_front();
          chk("u1 halted", halt1, e.halted);
          chk("u1 timeout", tmo1, e.timeout);
          chk("u1 cycle_count", cc1, e.cc);
          chk("u1 running low", run1, 0);
`ifdef CPU_RUN_PERF_EN
          chk("u1 change_count", chg1, e.chg);
`endif
        end
      end
      pd0 = done0;
      pd1 = done1;
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pc_in = '0;
    repeat (3) @(negedge clk);
    chk("rst cpu_rst", cpu_rst0, 1);
    chk("rst running", run0, 0);
    chk("rst done", done0, 0);
    chk("rst cc", cc0, 0);
    chk("rst flags", {halt0, tmo0, halt1, tmo1}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle cpu_rst", cpu_rst0, 1);

    run_one(0, 1'b0);  // the halt case from the test plan
    chk("halt case cc", cc0, 15);
    chk("halt case flags", {halt0, tmo0}, 2'b10);
`ifdef CPU_RUN_PERF_EN
    chk("halt case change_count", chg0, 8);
`endif
    run_one(1, 1'b1);  // timeout case; also a start from DONE and ignored starts
    chk("timeout case cc", cc0, 1000);
    chk("timeout case flags", {halt0, tmo0}, 2'b01);
    run_one(2, 1'b0);  // 7-sample holds do not halt u0
    chk("stall not halt", halt0, 0);
    run_one(3, 1'b0);  // u1: halt and timeout on the same edge
    chk("tie cc", cc1, 10);
    chk("tie flags", {halt1, tmo1}, 2'b10);
    reset_mid_run();
    for (int i = 0; i < 6; i++) run_one(4, i[0]);

    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
